// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment display driver
package seg7_pkg;

  localparam int DIGIT_COUNT = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; element n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - 4-bit nibble to active-low 7-segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_display_driver.sv
// rtl/seg7_display_driver.sv - memory-mapped 8-digit multiplexed hex display driver
// Optional leading-zero blanking enabled by SEG7_LEADING_ZERO_BLANK_EN.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = DIGIT_COUNT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [31:0]           WD,
  output logic [31:0]           RD,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            SEG,
  output logic                  DP
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [31:0]      value_q;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic             div_wrap;
  logic [3:0]       nibble;
  logic [6:0]       seg_pattern;
  logic             blank;

  assign RD       = value_q;
  assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign nibble   = value_q[{digit_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_pattern)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] top_idx;

  // Highest nonzero nibble; stays 0 for a zero word so digit 0 is always shown.
  always_comb begin
    top_idx = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'h0) begin
        top_idx = IDX_W'(i);
      end
    end
  end

  assign blank = (digit_idx > top_idx);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      value_q   <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      AN        <= '1;
      SEG       <= SEG_BLANK;
      DP        <= 1'b1;
    end else begin
      if (WE) begin
        value_q <= WD;
      end
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end
      // Outputs use the pre-edge index and value, so they trail state by one cycle.
      AN  <= blank ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
      SEG <= blank ? SEG_BLANK : seg_pattern;
      DP  <= 1'b1;
    end
  end

endmodule
